// File: rtl/tx_scheduler_if.sv
// Bundles the requester bus and the TX sequencer handshake of the reply scheduler.
// The slave modport is the scheduler side. The master modport is the requester/sequencer side.
interface tx_scheduler_if;
  logic [3:0]  req;
  logic [7:0]  rq_nbits;
  logic        rq_docrc;
  logic [3:0]  gnt;
  logic        word_req;
  logic [15:0] word_data;
  logic        word_valid;
  logic        seq_reset;
  logic        seq_docrc;
  logic        databitsrc;
  logic        datadone;
  logic        dataclk;
  logic        txsetupdone;
  logic        txdone;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  modport slave (
    input  req, rq_nbits, rq_docrc, word_data, word_valid, dataclk, txsetupdone, txdone,
    output gnt, word_req, seq_reset, seq_docrc, databitsrc, datadone, busy, done, err, err_code
  );

  modport master (
    output req, rq_nbits, rq_docrc, word_data, word_valid, dataclk, txsetupdone, txdone,
    input  gnt, word_req, seq_reset, seq_docrc, databitsrc, datadone, busy, done, err, err_code
  );
endinterface

// File: rtl/tx_scheduler.sv
// Round-robin reply scheduler. It feeds a TX sequencer one data bit per dataclk rise.
// Words come from the granted requester through a one-word prefetch buffer.
module tx_scheduler (
  input  logic          oscclk,
  input  logic          reset,
  tx_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_LOAD, S_ARM, S_SEND, S_FINISH, S_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  gidx_q, gidx_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  nbits_q, nbits_d;
  logic        docrc_q, docrc_d;
  logic [15:0] sr_q, sr_d;
  logic [15:0] buf_q, buf_d;
  logic        buf_full_q, buf_full_d;
  logic [4:0]  words_left_q, words_left_d;
  logic [7:0]  rise_cnt_q, rise_cnt_d;
  logic        databitsrc_q, databitsrc_d;
  logic        datadone_q, datadone_d;
  logic [15:0] wd_q, wd_d;
  logic        dclk_prev_q, dclk_prev_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic [1:0]  pick_idx, cand;
  logic        pick_found;
  logic        word_req_c, dclk_rise, req_lost, in_tx, abort, success;
  logic [1:0]  abort_code;

  assign dclk_rise = bus.dataclk & ~dclk_prev_q;
  assign req_lost  = (bus.req & gnt_q) == 4'b0000;
  assign in_tx     = state_q inside {S_ARM, S_SEND, S_FINISH};

  // Search starts at the slot after the last granted requester.
  always_comb begin
    pick_idx   = ptr_q;
    pick_found = 1'b0;
    cand       = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!pick_found && bus.req[cand]) begin
        pick_idx   = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gidx_d       = gidx_q;
    ptr_d        = ptr_q;
    nbits_d      = nbits_q;
    docrc_d      = docrc_q;
    sr_d         = sr_q;
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    words_left_d = words_left_q;
    rise_cnt_d   = rise_cnt_q;
    databitsrc_d = databitsrc_q;
    datadone_d   = datadone_q;
    dclk_prev_d  = bus.dataclk;
    done_d       = 1'b0;
    err_d        = 1'b0;
    err_code_d   = 2'd0;
    abort        = 1'b0;
    abort_code   = 2'd0;
    success      = 1'b0;
    wd_d         = in_tx ? wd_q + 16'd1 : 16'd0;

    word_req_c = 1'b0;
    if (state_q == S_LOAD)
      word_req_c = 1'b1;
    else if (in_tx)
      word_req_c = !buf_full_q && (words_left_q != 5'd0);

    if (in_tx && word_req_c && bus.word_valid) begin
      buf_d        = bus.word_data;
      buf_full_d   = 1'b1;
      words_left_d = words_left_q - 5'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gnt_d   = 4'b0001 << pick_idx;
          gidx_d  = pick_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        nbits_d      = bus.rq_nbits;
        docrc_d      = bus.rq_docrc;
        words_left_d = {1'b0, bus.rq_nbits[7:4]} + {4'b0000, |bus.rq_nbits[3:0]};
        if (req_lost) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else if (bus.rq_nbits == 8'd0) begin
          success = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (req_lost) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else if (bus.word_valid) begin
          sr_d         = bus.word_data;
          words_left_d = words_left_q - 5'd1;
          state_d      = S_ARM;
        end
      end
      S_ARM: begin
        if (req_lost) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else if (wd_d == 16'hFFFF) begin
          abort      = 1'b1;
          abort_code = 2'd2;
        end else if (bus.txsetupdone) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (datadone_q) begin
          state_d = S_FINISH;
        end else if (dclk_rise && (rise_cnt_q < nbits_q)) begin
          rise_cnt_d = rise_cnt_q + 8'd1;
          if ((rise_cnt_q + 8'd1) == nbits_q)
            datadone_d = 1'b1;
          // Each 16th rise starts a new word, so that bit must come from the prefetch buffer.
          if ((rise_cnt_q != 8'd0) && (rise_cnt_q[3:0] == 4'd0)) begin
            if (buf_full_q) begin
              databitsrc_d = buf_q[15];
              sr_d         = {buf_q[14:0], 1'b0};
              buf_full_d   = 1'b0;
            end else begin
              abort      = 1'b1;
              abort_code = 2'd1;
            end
          end else begin
            databitsrc_d = sr_q[15];
            sr_d         = {sr_q[14:0], 1'b0};
          end
        end
        if (!abort && req_lost) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else if (!abort && wd_d == 16'hFFFF) begin
          abort      = 1'b1;
          abort_code = 2'd2;
        end
      end
      S_FINISH: begin
        if (bus.txdone) begin
          success = 1'b1;
        end else if (req_lost) begin
          abort      = 1'b1;
          abort_code = 2'd3;
        end else if (wd_d == 16'hFFFF) begin
          abort      = 1'b1;
          abort_code = 2'd2;
        end
      end
      S_RELEASE: begin
        ptr_d   = gidx_q + 2'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_RELEASE;
      err_d      = 1'b1;
      err_code_d = abort_code;
    end else if (success) begin
      state_d = S_RELEASE;
      done_d  = 1'b1;
    end

    if (state_d == S_RELEASE) begin
      gnt_d        = 4'b0000;
      datadone_d   = 1'b0;
      databitsrc_d = 1'b0;
      buf_full_d   = 1'b0;
      words_left_d = 5'd0;
      rise_cnt_d   = 8'd0;
      docrc_d      = 1'b0;
    end
  end

  always_ff @(posedge oscclk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      gnt_q        <= 4'b0000;
      gidx_q       <= 2'd0;
      ptr_q        <= 2'd0;
      nbits_q      <= 8'd0;
      docrc_q      <= 1'b0;
      sr_q         <= 16'd0;
      buf_q        <= 16'd0;
      buf_full_q   <= 1'b0;
      words_left_q <= 5'd0;
      rise_cnt_q   <= 8'd0;
      databitsrc_q <= 1'b0;
      datadone_q   <= 1'b0;
      wd_q         <= 16'd0;
      dclk_prev_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gidx_q       <= gidx_d;
      ptr_q        <= ptr_d;
      nbits_q      <= nbits_d;
      docrc_q      <= docrc_d;
      sr_q         <= sr_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      words_left_q <= words_left_d;
      rise_cnt_q   <= rise_cnt_d;
      databitsrc_q <= databitsrc_d;
      datadone_q   <= datadone_d;
      wd_q         <= wd_d;
      dclk_prev_q  <= dclk_prev_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.word_req   = word_req_c;
  assign bus.seq_reset  = state_q inside {S_IDLE, S_GRANT, S_LOAD, S_RELEASE};
  assign bus.seq_docrc  = docrc_q;
  assign bus.databitsrc = databitsrc_q;
  assign bus.datadone   = datadone_q;
  assign bus.busy       = state_q != S_IDLE;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: round-robin grants, bit streaming, underrun,
// watchdog expiry, zero-length replies and reset in the middle of a transfer.
module tb_tx_scheduler;

  logic oscclk = 1'b0;
  logic reset;
  tx_scheduler_if bus();

  tx_scheduler dut (
    .oscclk (oscclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 oscclk = ~oscclk;

  int          check_count = 0;
  int          error_count = 0;
  int          cyc = 0;
  int          cyc_arm = 0;
  logic        b;
  logic [19:0] bits20;
  logic [15:0] bits16;
  logic [3:0]  exp_g [7] = '{4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0010};
  logic        exp_d [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic step();
    @(posedge oscclk);
    #1;
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) else begin
      error_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic [7:0] nb, input logic dc);
    bus.req      = r;
    bus.rq_nbits = nb;
    bus.rq_docrc = dc;
  endtask

  task automatic supply_word(input logic [15:0] w);
    int n = 0;
    while (!bus.word_req && n < 20) begin
      step();
      n++;
    end
    check_output("word_req_seen", 32'(bus.word_req), 32'd1);
    bus.word_data  = w;
    bus.word_valid = 1'b1;
    step();
    bus.word_valid = 1'b0;
  endtask

  task automatic dataclk_rise(output logic bit_out);
    bus.dataclk = 1'b1;
    step();
    bit_out = bus.databitsrc;
    bus.dataclk = 1'b0;
    step();
  endtask

  task automatic wait_flag(input string tag);
    int n = 0;
    while (!(bus.done || bus.err) && n < 50) begin
      step();
      n++;
    end
    check_output(tag, 32'(bus.done | bus.err), 32'd1);
  endtask

  task automatic arm_sequencer();
    bus.txsetupdone = 1'b1;
    step();
    bus.txsetupdone = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    bus.req = 4'b0000; bus.rq_nbits = 8'd0; bus.rq_docrc = 1'b0;
    bus.word_data = 16'h0000; bus.word_valid = 1'b0; bus.dataclk = 1'b0;
    bus.txsetupdone = 1'b0; bus.txdone = 1'b0;
    reset = 1'b0;
    step(); step(); step();
    check_output("rst_gnt",       32'(bus.gnt),       32'h0);
    check_output("rst_busy",      32'(bus.busy),      32'h0);
    check_output("rst_seq_reset", 32'(bus.seq_reset), 32'h1);
    check_output("rst_word_req",  32'(bus.word_req),  32'h0);
    check_output("rst_done_err",  32'({bus.done, bus.err, bus.err_code}), 32'h0);
    reset = 1'b1;
    step();

    // 20-bit reply across two words with CRC flag.
    apply_stimulus(4'b0001, 8'd20, 1'b1);
    step();
    check_output("A_gnt",  32'(bus.gnt),  32'h1);
    check_output("A_busy", 32'(bus.busy), 32'h1);
    step();
    check_output("A_load_word_req", 32'(bus.word_req),  32'h1);
    check_output("A_seq_docrc",     32'(bus.seq_docrc), 32'h1);
    check_output("A_load_seq_rst",  32'(bus.seq_reset), 32'h1);
    supply_word(16'hA5C3);
    check_output("A_arm_seq_rst", 32'(bus.seq_reset), 32'h0);
    supply_word(16'hF000);
    check_output("A_buf_full_no_req", 32'(bus.word_req), 32'h0);
    arm_sequencer();
    bits20 = '0;
    for (int k = 0; k < 20; k++) begin
      dataclk_rise(b);
      bits20 = {bits20[18:0], b};
      if (k == 18) check_output("A_datadone_r19", 32'(bus.datadone), 32'h0);
    end
    check_output("A_bits",         32'(bits20),        32'hA5C3F);
    check_output("A_datadone_r20", 32'(bus.datadone),  32'h1);
    dataclk_rise(b);
    check_output("A_extra_rise",   32'({b, bus.datadone}), 32'h3);
    bus.txdone = 1'b1;
    wait_flag("A_finish_seen");
    check_output("A_done",     32'(bus.done),      32'h1);
    check_output("A_no_err",   32'(bus.err),       32'h0);
    check_output("A_rel_gnt",  32'(bus.gnt),       32'h0);
    check_output("A_rel_srst", 32'(bus.seq_reset), 32'h1);
    bus.txdone = 1'b0;
    bus.req = 4'b0000;
    step();
    check_output("A_idle_busy", 32'(bus.busy), 32'h0);
    check_output("A_idle_done", 32'(bus.done), 32'h0);

    // Zero-length replies with two persistent requesters.
    apply_stimulus(4'b0110, 8'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      check_output("B_gnt",      32'(bus.gnt),       32'(exp_g[i]));
      check_output("B_done",     32'(bus.done),      32'(exp_d[i]));
      check_output("B_seq_rst",  32'(bus.seq_reset), 32'h1);
      check_output("B_word_req", 32'(bus.word_req),  32'h0);
    end
    step();
    check_output("B_last_done", 32'({bus.done, bus.err, bus.gnt}), 32'h20);
    bus.req = 4'b0000;
    step();
    check_output("B_idle_busy", 32'(bus.busy), 32'h0);

    // Exactly one word; the missing second word must not underrun.
    apply_stimulus(4'b0100, 8'd16, 1'b0);
    step();
    check_output("C_gnt", 32'(bus.gnt), 32'h4);
    supply_word(16'h8001);
    check_output("C_no_prefetch", 32'(bus.word_req), 32'h0);
    arm_sequencer();
    bits16 = '0;
    for (int k = 0; k < 16; k++) begin
      dataclk_rise(b);
      bits16 = {bits16[14:0], b};
    end
    check_output("C_bits",     32'(bits16),       32'h8001);
    check_output("C_datadone", 32'(bus.datadone), 32'h1);
    dataclk_rise(b);
    dataclk_rise(b);
    check_output("C_no_underrun", 32'(bus.err), 32'h0);
    bus.txdone = 1'b1;
    wait_flag("C_finish_seen");
    check_output("C_done", 32'({bus.done, bus.err}), 32'h2);
    bus.txdone = 1'b0;
    bus.req = 4'b0000;
    step();

    // Reset on rise 5 of a transfer granted to requester 3.
    apply_stimulus(4'b1000, 8'd20, 1'b1);
    step();
    check_output("E_gnt", 32'(bus.gnt), 32'h8);
    supply_word(16'hFFFF);
    supply_word(16'hFFFF);
    arm_sequencer();
    for (int k = 0; k < 4; k++) dataclk_rise(b);
    check_output("E_bit4", 32'(bus.databitsrc), 32'h1);
    bus.dataclk = 1'b1;
    reset = 1'b0;
    step();
    check_output("E_gnt0",     32'(bus.gnt),        32'h0);
    check_output("E_busy0",    32'(bus.busy),       32'h0);
    check_output("E_seq_rst",  32'(bus.seq_reset),  32'h1);
    check_output("E_docrc0",   32'(bus.seq_docrc),  32'h0);
    check_output("E_bit0",     32'(bus.databitsrc), 32'h0);
    check_output("E_ddone0",   32'(bus.datadone),   32'h0);
    check_output("E_word_req", 32'(bus.word_req),   32'h0);
    check_output("E_flags0",   32'({bus.done, bus.err, bus.err_code}), 32'h0);
    reset = 1'b1;
    bus.dataclk = 1'b0;

    // After reset the search restarts at requester 0; then force an underrun at rise 17.
    apply_stimulus(4'b1001, 8'd17, 1'b0);
    step();
    check_output("D_gnt_from0", 32'(bus.gnt), 32'h1);
    supply_word(16'hFFFF);
    check_output("D_prefetch_req", 32'(bus.word_req), 32'h1);
    arm_sequencer();
    for (int k = 0; k < 16; k++) dataclk_rise(b);
    check_output("D_err_before17", 32'({bus.err, bus.databitsrc}), 32'h1);
    bus.dataclk = 1'b1;
    step();
    check_output("D_err",      32'(bus.err),      32'h1);
    check_output("D_err_code", 32'(bus.err_code), 32'h1);
    check_output("D_no_done",  32'(bus.done),     32'h0);
    check_output("D_gnt0",     32'(bus.gnt),      32'h0);
    bus.req = 4'b0000;
    bus.dataclk = 1'b0;
    step();
    check_output("D_idle", 32'({bus.busy, bus.err}), 32'h0);

    // Watchdog expiry with txdone held low.
    apply_stimulus(4'b0010, 8'd8, 1'b0);
    step();
    check_output("F_gnt", 32'(bus.gnt), 32'h2);
    supply_word(16'h00FF);
    cyc_arm = cyc;
    arm_sequencer();
    for (int k = 0; k < 8; k++) dataclk_rise(b);
    while (!(bus.err || bus.done) && (cyc - cyc_arm) < 70000) step();
    check_output("F_err",      32'(bus.err),         32'h1);
    check_output("F_cycles",   32'(cyc - cyc_arm),   32'd65535);
    check_output("F_err_code", 32'(bus.err_code),    32'h2);
    check_output("F_seq_rst",  32'(bus.seq_reset),   32'h1);
    check_output("F_no_done",  32'(bus.done),        32'h0);
    bus.req = 4'b0000;
    step();
    check_output("F_idle", 32'({bus.busy, bus.err, bus.seq_reset}), 32'h1);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
